// File: rtl/q2n_pkg.sv
// q2n_pkg: shared opcode values, FSM state encoding and opcode classification
// for the Q2-family serial datapath.
package q2n_pkg;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_LDX = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the ALU ops that walk through the bit-serial path.
    function automatic logic is_serial(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_NOR);
    endfunction

endpackage

// File: rtl/q2n_alu_bit.sv
// q2n_alu_bit: one-bit ADD/SUB/AND/NOR cell with a registered carry.
// The carry is preset on load (1 for SUB so that A+~B+1 forms A-B) and
// advances once per enabled clock. cout is the carry out of the current bit,
// which on the last bit is the architectural carry.
module q2n_alu_bit
    import q2n_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       cin_init,
    input  logic       en,
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       res,
    output logic       cout
);

    logic carry_q;
    logic b_eff;

    assign b_eff = b ^ (op == OP_SUB);
    assign cout  = (a & b_eff) | (a & carry_q) | (b_eff & carry_q);

    // Result bit for the selected operation.
    always_comb begin
        res = 1'b0;
        case (op)
            OP_ADD, OP_SUB: res = a ^ b_eff ^ carry_q;
            OP_AND:         res = a & b;
            OP_NOR:         res = ~(a | b);
            default:        res = 1'b0;
        endcase
    end

    // Carry register: preset on accept, ripple forward one bit per shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= cin_init;
        end else if (en) begin
            carry_q <= cout;
        end
    end

endmodule

// File: rtl/q2n_serial_dp.sv
// q2n_serial_dp: Q2-family datapath with accumulator A, index X, program
// counter P and flag F, sequenced by an IDLE/SHIFT/DONE FSM.
// Build option: define Q2N_PARALLEL_ALU_EN to evaluate ADD/SUB/AND/NOR in one
// cycle with a full-width adder; undefined builds use the bit-serial cell.
//
// Handshake: start/op/din are sampled on a rising edge only while busy=0
// (state IDLE); that edge is the accept edge and busy rises right after it.
// busy stays high until the DONE cycle ends; done is high for exactly that
// one cycle, during which a_out/x_out/p_out/f_out hold the final result.
// start seen while busy=1 is dropped, not queued.
module q2n_serial_dp
    import q2n_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             dep,
    input  logic             incp,
    input  logic [WIDTH-1:0] sw,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] p_out,
    output logic             f_out,
    output logic [1:0]       fsm_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, x_q, p_q;
    logic             f_q;
    logic             accept;

    assign accept    = (state_q == ST_IDLE) && start;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign a_out     = a_q;
    assign x_out     = x_q;
    assign p_out     = p_q;
    assign f_out     = f_q;
    assign fsm_state = state_q;

`ifdef Q2N_PARALLEL_ALU_EN
    logic             sub_sel;
    logic [WIDTH:0]   sum;

    // A + din, or A + ~din + 1 for SUB; bit WIDTH is the carry out.
    assign sub_sel = (op == OP_SUB);
    assign sum     = {1'b0, a_q} + {1'b0, din ^ {WIDTH{sub_sel}}} + {{WIDTH{1'b0}}, sub_sel};
`else
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             res_bit;
    logic             cout_bit;

    q2n_alu_bit u_alu_bit (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_serial(op)),
        .cin_init (op == OP_SUB),
        .en       (state_q == ST_SHIFT),
        .op       (op_q),
        .a        (a_q[0]),
        .b        (b_q[0]),
        .res      (res_bit),
        .cout     (cout_bit)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: serial ops detour through SHIFT, everything else goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef Q2N_PARALLEL_ALU_EN
                    state_d = ST_DONE;
`else
                    state_d = is_serial(op) ? ST_SHIFT : ST_DONE;
`endif
                end
            end
`ifndef Q2N_PARALLEL_ALU_EN
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural registers: op execution on accept, serial shifting, panel functions while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            x_q <= '0;
            p_q <= '0;
            f_q <= 1'b0;
`ifndef Q2N_PARALLEL_ALU_EN
            b_q   <= '0;
            cnt_q <= '0;
            op_q  <= OP_LDA;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_LDA: a_q <= din;
                            OP_SHR: begin
                                a_q <= {f_q, a_q[WIDTH-1:1]};
                                f_q <= a_q[0];
                            end
                            OP_LDX: x_q <= din;
                            OP_JMP: p_q <= din;
`ifdef Q2N_PARALLEL_ALU_EN
                            OP_ADD, OP_SUB: begin
                                a_q <= sum[WIDTH-1:0];
                                f_q <= sum[WIDTH];
                            end
                            OP_AND: a_q <= a_q & din;
                            default: a_q <= ~(a_q | din);
`else
                            default: begin
                                b_q   <= din;
                                op_q  <= op;
                                cnt_q <= CW'(WIDTH - 1);
                            end
`endif
                        endcase
                    end else if (dep) begin
                        a_q <= sw;
                    end else if (incp) begin
                        p_q <= p_q + WIDTH'(1);
                    end
                end
`ifndef Q2N_PARALLEL_ALU_EN
                ST_SHIFT: begin
                    a_q <= {res_bit, a_q[WIDTH-1:1]};
                    b_q <= {1'b0, b_q[WIDTH-1:1]};
                    if (cnt_q == '0) begin
                        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                            f_q <= cout_bit;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q2n_serial_dp.sv
// Directed bench for q2n_serial_dp (WIDTH=12). Expected register values are
// written out by hand per vector; a negedge monitor pops them on every done.
module tb_q2n_serial_dp;
    import q2n_pkg::*;

    localparam int W = 12;
`ifdef Q2N_PARALLEL_ALU_EN
    localparam int SER_LAT  = 1;
    localparam int RST_WAIT = 0;
`else
    localparam int SER_LAT  = W + 1;
    localparam int RST_WAIT = 5;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] din = '0;
    logic         dep = 1'b0;
    logic         incp = 1'b0;
    logic [W-1:0] sw = '0;
    logic         busy, done, f_out;
    logic [W-1:0] a_out, x_out, p_out;
    logic [1:0]   fsm_state;

    int n_chk = 0;
    int n_err = 0;
    int busy_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_x_q[$];
    logic [W-1:0] exp_p_q[$];
    logic         exp_f_q[$];
    int           exp_lat_q[$];

    q2n_serial_dp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .din       (din),
        .dep       (dep),
        .incp      (incp),
        .sw        (sw),
        .busy      (busy),
        .done      (done),
        .a_out     (a_out),
        .x_out     (x_out),
        .p_out     (p_out),
        .f_out     (f_out),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: counts busy cycles and checks results on each done
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1 expected no done (a=%h)", a_out);
                    end else begin
                        check("a_out", a_out, exp_q.pop_front());
                        check("x_out", x_out, exp_x_q.pop_front());
                        check("p_out", p_out, exp_p_q.pop_front());
                        check("f_out", W'(f_out), W'(exp_f_q.pop_front()));
                        check("busy_cycles", W'(busy_cnt), W'(exp_lat_q.pop_front()));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!busy && !done) break;
            @(negedge clk);
        end
        if (i == 100) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: got busy=%b expected idle within 100 cycles", busy);
        end
    endtask

    // Driver: push expectation, issue one op; hold keeps start high one extra
    // cycle with a different op (must be ignored); panel raises dep+incp with start.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] d,
                         input logic [W-1:0] ea, input logic [W-1:0] ex,
                         input logic [W-1:0] ep, input logic ef, input int lat,
                         input bit hold, input bit panel);
        exp_q.push_back(ea);
        exp_x_q.push_back(ex);
        exp_p_q.push_back(ep);
        exp_f_q.push_back(ef);
        exp_lat_q.push_back(lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        din   = d;
        dep   = panel;
        incp  = panel;
        @(negedge clk);
        dep  = 1'b0;
        incp = 1'b0;
        if (hold) begin
            op  = OP_LDA;
            din = 12'hABC;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
    endtask

    task automatic panel_cycles(input logic d, input logic i, input logic [W-1:0] s, input int n);
        @(negedge clk);
        dep  = d;
        incp = i;
        sw   = s;
        repeat (n) @(negedge clk);
        dep  = 1'b0;
        incp = 1'b0;
    endtask

    // Stimulus
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a", a_out, 12'h000);
        check("rst_f", W'(f_out), 12'h000);
        check("rst_busy", W'(busy), 12'h000);
        check("rst_done", W'(done), 12'h000);
        check("rst_state", W'(fsm_state), W'(ST_IDLE));
        rst = 1'b1;

        do_op(OP_LDA, 12'h123, 12'h123, 12'h000, 12'h000, 1'b0, 1, 0, 0);
        do_op(OP_LDX, 12'h456, 12'h123, 12'h456, 12'h000, 1'b0, 1, 0, 0);
        do_op(OP_JMP, 12'h789, 12'h123, 12'h456, 12'h789, 1'b0, 1, 0, 0);

        // Reset in the middle of an ADD: everything clears at once, no done afterwards
        @(negedge clk);
        start = 1'b1;
        op    = OP_ADD;
        din   = 12'h001;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (RST_WAIT) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_a", a_out, 12'h000);
        check("midrst_x", x_out, 12'h000);
        check("midrst_p", p_out, 12'h000);
        check("midrst_f", W'(f_out), 12'h000);
        check("midrst_busy", W'(busy), 12'h000);
        check("midrst_done", W'(done), 12'h000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_state", W'(fsm_state), W'(ST_IDLE));

        // Carry out of all-ones + 1
        do_op(OP_LDA, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 1'b0, 1, 0, 0);
        do_op(OP_ADD, 12'h001, 12'h000, 12'h000, 12'h000, 1'b1, SER_LAT, 0, 0);

        // Subtraction with and without borrow, then logic ops leaving F alone
        do_op(OP_LDA, 12'h005, 12'h005, 12'h000, 12'h000, 1'b1, 1, 0, 0);
        do_op(OP_SUB, 12'h007, 12'hFFE, 12'h000, 12'h000, 1'b0, SER_LAT, 0, 0);
        do_op(OP_SUB, 12'h001, 12'hFFD, 12'h000, 12'h000, 1'b1, SER_LAT, 0, 0);
        do_op(OP_AND, 12'h0F0, 12'h0F0, 12'h000, 12'h000, 1'b1, SER_LAT, 0, 0);
        do_op(OP_NOR, 12'h00F, 12'hF00, 12'h000, 12'h000, 1'b1, SER_LAT, 0, 0);

        // Rotate right through F; start held into the busy cycle is dropped
        do_op(OP_LDA, 12'h002, 12'h002, 12'h000, 12'h000, 1'b1, 1, 0, 0);
        do_op(OP_SHR, 12'h000, 12'h801, 12'h000, 12'h000, 1'b0, 1, 1, 0);
        do_op(OP_LDA, 12'h100, 12'h100, 12'h000, 12'h000, 1'b0, 1, 0, 0);
        do_op(OP_ADD, 12'h0FF, 12'h1FF, 12'h000, 12'h000, 1'b0, SER_LAT, 1, 0);
        do_op(OP_LDX, 12'h0A5, 12'h1FF, 12'h0A5, 12'h000, 1'b0, 1, 0, 0);
        do_op(OP_JMP, 12'hFFF, 12'h1FF, 12'h0A5, 12'hFFF, 1'b0, 1, 0, 0);

        // Panel functions while idle
        panel_cycles(1'b0, 1'b1, 12'h000, 1);
        check("incp_wrap_p", p_out, 12'h000);
        check("incp_wrap_a", a_out, 12'h1FF);
        check("incp_wrap_f", W'(f_out), 12'h000);
        panel_cycles(1'b1, 1'b0, 12'h5A5, 1);
        check("dep_a", a_out, 12'h5A5);
        panel_cycles(1'b1, 1'b1, 12'h3C3, 1);
        check("dep_prio_a", a_out, 12'h3C3);
        check("dep_prio_p", p_out, 12'h000);
        panel_cycles(1'b0, 1'b1, 12'h3C3, 3);
        check("incp_level_p", p_out, 12'h003);

        // start outranks dep and incp
        sw = 12'h777;
        do_op(OP_LDX, 12'h333, 12'h3C3, 12'h333, 12'h003, 1'b0, 1, 0, 1);
        check("start_prio_a", a_out, 12'h3C3);
        check("start_prio_p", p_out, 12'h003);

        // Rotate shifting a 1 into F, then an add that wraps to zero
        do_op(OP_SHR, 12'h000, 12'h1E1, 12'h333, 12'h003, 1'b1, 1, 0, 0);
        do_op(OP_ADD, 12'hE1F, 12'h000, 12'h333, 12'h003, 1'b1, SER_LAT, 0, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), 12'h000);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
